// File: rtl/mac_pe_db.sv
// mac_pe_db: weight-stationary MAC PE with double-buffered weight, chain loading and wrap/saturate arithmetic
module mac_pe_db #(
    parameter int IFMAP_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int OFMAP_WIDTH  = 32,
    parameter bit SATURATE     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           weight_wen,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_in,
    input  logic                           weight_swap,
    input  logic signed [IFMAP_WIDTH-1:0]  ifmap_in,
    input  logic signed [OFMAP_WIDTH-1:0]  ofmap_in,
    input  logic                           ovf_clr,
    output logic signed [IFMAP_WIDTH-1:0]  ifmap_out,
    output logic signed [OFMAP_WIDTH-1:0]  ofmap_out,
    output logic signed [WEIGHT_WIDTH-1:0] weight_out,
    output logic                           ovf_flag
);
    localparam int PW = IFMAP_WIDTH + WEIGHT_WIDTH;
    localparam int SW = (OFMAP_WIDTH > PW ? OFMAP_WIDTH : PW) + 1;
    localparam logic [OFMAP_WIDTH-1:0] MAXV = {1'b0, {(OFMAP_WIDTH-1){1'b1}}};
    localparam logic [OFMAP_WIDTH-1:0] MINV = {1'b1, {(OFMAP_WIDTH-1){1'b0}}};
    logic signed [WEIGHT_WIDTH-1:0] shadow, active;
    logic signed [PW-1:0]           prod;
    logic signed [SW-1:0]           sum;
    logic [SW-OFMAP_WIDTH:0]        top;
    logic                           ovf;
    logic [OFMAP_WIDTH-1:0]         res;
    assign weight_out = shadow;
    // full-precision product and sum; overflow when the bits above the result sign disagree
    always_comb begin
        prod = ifmap_in * active;
        sum  = {{(SW-PW){prod[PW-1]}}, prod} + {{(SW-OFMAP_WIDTH){ofmap_in[OFMAP_WIDTH-1]}}, ofmap_in};
        top  = sum[SW-1:OFMAP_WIDTH-1];
        ovf  = !((&top) || !(|top));
        res  = (SATURATE && ovf) ? (sum[SW-1] ? MINV : MAXV) : sum[OFMAP_WIDTH-1:0];
    end
    // weight path: shadow loads/shifts, active takes the pre-edge shadow on swap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (weight_wen) shadow <= weight_in;
            if (weight_swap) active <= shadow;
        end
    end
    // datapath registers and sticky overflow, where a new overflow beats a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifmap_out <= '0;
            ofmap_out <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            if (en) begin
                ifmap_out <= ifmap_in;
                ofmap_out <= res;
            end
            ovf_flag <= (en && ovf) ? 1'b1 : ovf_clr ? 1'b0 : ovf_flag;
        end
    end
endmodule

// File: tb/tb_mac_pe_db.sv
// tb_mac_pe_db: directed and randomized checks of mac_pe_db in wrap, saturate and 3-deep chain configurations
module tb_mac_pe_db;
    logic clk = 0, rst_n = 0, en = 0, weight_wen = 0, weight_swap = 0, ovf_clr = 0;
    logic signed [15:0] weight_in = 0, ifmap_in = 0;
    logic signed [31:0] ofmap_in = 0;
    logic signed [15:0] d0_ifo, d1_ifo, d0_wo, d1_wo;
    logic signed [31:0] d0_ofo, d1_ofo;
    logic d0_ovf, d1_ovf;
    logic signed [15:0] c_win[3], c_ifo[3], c_wo[3];
    logic signed [31:0] c_ofo[3];
    logic c_ovf[3];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mac_pe_db #(.SATURATE(0)) d0 (.clk(clk), .rst_n(rst_n), .en(en), .weight_wen(weight_wen), .weight_in(weight_in),
        .weight_swap(weight_swap), .ifmap_in(ifmap_in), .ofmap_in(ofmap_in), .ovf_clr(ovf_clr),
        .ifmap_out(d0_ifo), .ofmap_out(d0_ofo), .weight_out(d0_wo), .ovf_flag(d0_ovf));
    mac_pe_db #(.SATURATE(1)) d1 (.clk(clk), .rst_n(rst_n), .en(en), .weight_wen(weight_wen), .weight_in(weight_in),
        .weight_swap(weight_swap), .ifmap_in(ifmap_in), .ofmap_in(ofmap_in), .ovf_clr(ovf_clr),
        .ifmap_out(d1_ifo), .ofmap_out(d1_ofo), .weight_out(d1_wo), .ovf_flag(d1_ovf));

    assign c_win[0] = weight_in;
    assign c_win[1] = c_wo[0];
    assign c_win[2] = c_wo[1];
    for (genvar g = 0; g < 3; g++) begin : col
        mac_pe_db c (.clk(clk), .rst_n(rst_n), .en(en), .weight_wen(weight_wen), .weight_in(c_win[g]),
            .weight_swap(weight_swap), .ifmap_in(ifmap_in), .ofmap_in(ofmap_in), .ovf_clr(ovf_clr),
            .ifmap_out(c_ifo[g]), .ofmap_out(c_ofo[g]), .weight_out(c_wo[g]), .ovf_flag(c_ovf[g]));
    end

    // reference: exact integer MAC, then wrap or clamp to 32-bit signed; returns {overflow, result}
    function automatic logic [32:0] mac(input longint a, input longint w, input longint o, input bit sat);
        longint s = a * w + o;
        bit v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        logic [31:0] r = s[31:0];
        if (sat && v) r = (s < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
        return {v, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; weight_wen = 0; weight_swap = 0; ovf_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1; weight_wen = 1; weight_swap = 1; ovf_clr = 0;
        weight_in = 16'sd99; ifmap_in = 16'sd5; ofmap_in = 32'sd7;
        tick();
        idle();
        tests++; if (d0_ofo !== 32'sd0) begin fails++; $display("FAIL reset_ofmap got %0d exp 0", d0_ofo); end
        tests++; if (d0_ifo !== 16'sd0) begin fails++; $display("FAIL reset_ifmap got %0d exp 0", d0_ifo); end
        tests++; if (d0_wo !== 16'sd0) begin fails++; $display("FAIL reset_weight_out got %0d exp 0", d0_wo); end
        tests++; if (d1_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b exp 0", d1_ovf); end
        rst_n = 1;
    endtask

    task automatic test_basic();
        weight_wen = 1; weight_in = -16'sd5; tick();
        weight_wen = 0; weight_swap = 1; tick();
        weight_swap = 0; en = 1; ifmap_in = 16'sd12; ofmap_in = -32'sd7; tick();
        tests++; if (d0_ofo !== -32'sd67) begin fails++; $display("FAIL basic_ofmap1 got %0d exp -67", d0_ofo); end
        tests++; if (d0_ifo !== 16'sd12) begin fails++; $display("FAIL basic_ifmap1 got %0d exp 12", d0_ifo); end
        ifmap_in = 16'sd3; ofmap_in = 32'sd16; tick();
        tests++; if (d0_ofo !== 32'sd1) begin fails++; $display("FAIL basic_ofmap2 got %0d exp 1", d0_ofo); end
        tests++; if (d0_ifo !== 16'sd3) begin fails++; $display("FAIL basic_ifmap2 got %0d exp 3", d0_ifo); end
        en = 0; ifmap_in = 16'sd77; ofmap_in = 32'sd1000;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (d0_ofo !== 32'sd1 || d0_ifo !== 16'sd3) begin fails++; $display("FAIL basic_hold%0d got %0d/%0d exp 1/3", i, d0_ofo, d0_ifo); end
        end
    endtask

    task automatic test_double_buffer();
        en = 1; ifmap_in = 16'sd2; ofmap_in = 32'sd0; weight_wen = 1; weight_in = 16'sd7; tick();
        weight_wen = 0; weight_in = 16'sd0;
        tests++; if (d0_ofo !== -32'sd10 || d0_wo !== 16'sd7) begin fails++; $display("FAIL dbuf_load got %0d/%0d exp -10/7", d0_ofo, d0_wo); end
        tick();
        tests++; if (d0_ofo !== -32'sd10 || d0_wo !== 16'sd7) begin fails++; $display("FAIL dbuf_hold got %0d/%0d exp -10/7", d0_ofo, d0_wo); end
        weight_swap = 1; tick();
        weight_swap = 0;
        tests++; if (d0_ofo !== -32'sd10) begin fails++; $display("FAIL dbuf_swap_edge got %0d exp -10", d0_ofo); end
        tick();
        tests++; if (d0_ofo !== 32'sd14 || d0_wo !== 16'sd7) begin fails++; $display("FAIL dbuf_after_swap got %0d/%0d exp 14/7", d0_ofo, d0_wo); end
        idle();
    endtask

    task automatic test_wen_swap();
        weight_wen = 1; weight_in = 16'sd4; tick();
        weight_in = 16'sd9; weight_swap = 1; tick();
        idle();
        tests++; if (d0_wo !== 16'sd9) begin fails++; $display("FAIL wen_swap_weight_out got %0d exp 9", d0_wo); end
        en = 1; ifmap_in = 16'sd1; ofmap_in = 32'sd0; tick();
        tests++; if (d0_ofo !== 32'sd4) begin fails++; $display("FAIL wen_swap_active got %0d exp 4", d0_ofo); end
        idle();
    endtask

    task automatic test_overflow();
        weight_wen = 1; weight_in = -16'sd32768; tick();
        weight_wen = 0; weight_swap = 1; tick();
        weight_swap = 0; en = 1; ifmap_in = -16'sd32768; ofmap_in = 32'sd2147483647; tick();
        tests++; if (d1_ofo !== 32'sd2147483647 || d1_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sat got %0d/%0b exp 2147483647/1", d1_ofo, d1_ovf); end
        tests++; if (d0_ofo !== -32'sd1073741825 || d0_ovf !== 1'b1) begin fails++; $display("FAIL ovf_wrap got %0d/%0b exp -1073741825/1", d0_ofo, d0_ovf); end
        ifmap_in = 16'sd0; ofmap_in = 32'sd0; en = 0; tick();
        tests++; if (d1_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %0b exp 1", d1_ovf); end
        en = 1; ovf_clr = 1; tick();
        tests++; if (d1_ovf !== 1'b0 || d1_ofo !== 32'sd0) begin fails++; $display("FAIL ovf_clear got %0b/%0d exp 0/0", d1_ovf, d1_ofo); end
        ifmap_in = -16'sd32768; ofmap_in = 32'sd2147483647; tick();
        tests++; if (d1_ovf !== 1'b1 || d0_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set_beats_clr got %0b/%0b exp 1/1", d1_ovf, d0_ovf); end
        en = 0; ovf_clr = 1; tick();
        tests++; if (d1_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clr_idle got %0b exp 0", d1_ovf); end
        ovf_clr = 0; tick();
        tests++; if (d1_ovf !== 1'b0) begin fails++; $display("FAIL ovf_no_set_when_disabled got %0b exp 0", d1_ovf); end
        ofmap_in = -32'sd2147483648; ifmap_in = -16'sd32768; weight_wen = 1; weight_in = 16'sd32767; tick();
        weight_wen = 0; weight_swap = 1; tick();
        weight_swap = 0; en = 1; tick();
        tests++; if (d1_ofo !== -32'sd2147483648 || d1_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sat_neg got %0d/%0b exp -2147483648/1", d1_ofo, d1_ovf); end
        idle();
    endtask

    task automatic test_chain();
        weight_wen = 1;
        for (int i = 5; i <= 7; i++) begin weight_in = 16'(i); tick(); end
        weight_wen = 0; weight_swap = 1; tick();
        weight_swap = 0; en = 1; ifmap_in = 16'sd1; ofmap_in = 32'sd0; tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if (c_ofo[i] !== 32'(7 - i)) begin fails++; $display("FAIL chain_active%0d got %0d exp %0d", i, c_ofo[i], 7 - i); end
        end
        tests++; if (c_wo[2] !== 16'sd5) begin fails++; $display("FAIL chain_bottom_shadow got %0d exp 5", c_wo[2]); end
        ifmap_in = 16'sd3; rst_n = 0; tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (c_ofo[i] !== 0 || c_ifo[i] !== 0 || c_wo[i] !== 0 || c_ovf[i] !== 1'b0) begin
                fails++; $display("FAIL chain_reset%0d got %0d/%0d/%0d/%0b exp 0", i, c_ofo[i], c_ifo[i], c_wo[i], c_ovf[i]); end
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if (c_ofo[i] !== 0 || c_ifo[i] !== 16'sd3) begin fails++; $display("FAIL chain_post_reset%0d got %0d/%0d exp 0/3", i, c_ofo[i], c_ifo[i]); end
        end
        idle();
    endtask

    task automatic test_random();
        longint shadow = 0, active = 0, ifo = 0, ofo0 = 0, ofo1 = 0;
        bit ovf = 0;
        logic [32:0] r0, r1;
        rst_n = 0; tick(); rst_n = 1;
        for (int n = 0; n < 300; n++) begin
            en = 1'($urandom_range(0, 3) != 0);
            weight_wen = 1'($urandom_range(0, 2) == 0);
            weight_swap = 1'($urandom_range(0, 3) == 0);
            ovf_clr = 1'($urandom_range(0, 4) == 0);
            weight_in = ($urandom_range(0, 3) == 0) ? -16'sd32768 : 16'($urandom);
            ifmap_in = ($urandom_range(0, 3) == 0) ? 16'sh7fff : 16'($urandom);
            ofmap_in = ($urandom_range(0, 2) == 0) ? 32'sh7fff_0000 : 32'($urandom);
            r0 = mac(longint'(ifmap_in), active, longint'(ofmap_in), 0);
            r1 = mac(longint'(ifmap_in), active, longint'(ofmap_in), 1);
            if (en) begin
                ifo = longint'(ifmap_in);
                ofo0 = longint'($signed(r0[31:0]));
                ofo1 = longint'($signed(r1[31:0]));
            end
            ovf = (en && r0[32]) ? 1'b1 : ovf_clr ? 1'b0 : ovf;
            if (weight_swap) active = shadow;
            if (weight_wen) shadow = longint'(weight_in);
            tick();
            tests++; if (longint'(d0_ofo) != ofo0 || longint'(d0_ifo) != ifo || longint'(d0_wo) != shadow || d0_ovf !== ovf) begin
                fails++; $display("FAIL rand_wrap[%0d] got %0d/%0d/%0d/%0b exp %0d/%0d/%0d/%0b", n, d0_ofo, d0_ifo, d0_wo, d0_ovf, ofo0, ifo, shadow, ovf); end
            tests++; if (longint'(d1_ofo) != ofo1 || d1_ovf !== ovf) begin
                fails++; $display("FAIL rand_sat[%0d] got %0d/%0b exp %0d/%0b", n, d1_ofo, d1_ovf, ofo1, ovf); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_wen_swap();
        test_overflow();
        test_chain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
